nexys_starship_spawner: RTL and testbench

//  Pseudo-random monster spawn source for Nexys Starship. Sits upstream of the per-lane monster FSMs (top/bottom/left/right).

---
 rtl/nexys_starship_pkg.sv | 25 ++
 rtl/nexys_starship_spawner_lfsr16.sv | 32 +++
 rtl/nexys_starship_spawner.sv | 200 ++++++++++++++++++++
 tb/tb_nexys_starship_spawner.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nexys_starship_pkg.sv
// rtl/nexys_starship_pkg.sv - shared state encodings, lane indices and LFSR taps for the spawner
package nexys_starship_pkg;

    // One-hot FSM states; bit order matches {q_Cool, q_Offer, q_Run, q_Idle}
    localparam logic [3:0] IDLE  = 4'b0001;
    localparam logic [3:0] RUN   = 4'b0010;
    localparam logic [3:0] OFFER = 4'b0100;
    localparam logic [3:0] COOL  = 4'b1000;

    localparam int NUM_LANES = 4;

    // Lane indices into occupied/spawn_ack/spawn_req
    localparam logic [1:0] LANE_T = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_L = 2'd2;
    localparam logic [1:0] LANE_R = 2'd3;

    // Feedback taps 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/nexys_starship_spawner_lfsr16.sv
// rtl/nexys_starship_spawner_lfsr16.sv - free-running 16-bit Fibonacci LFSR shared with effect blocks
module starship_lfsr16
    import nexys_starship_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic [15:0] seed_eff;

    // A zero seed would lock the register at zero, so substitute 1; shift in the tap parity
    always_comb begin
        seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
        q_d      = {q_q[14:0], ^(q_q & LFSR_TAPS)};
    end

    // Advances every clock regardless of game state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q_q <= seed_eff;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/nexys_starship_spawner.sv
// rtl/nexys_starship_spawner.sv - spawn FSM, tick/cooldown/ramp counters, free-lane rotator (ramp: NEXYS_STARSHIP_SPAWN_RAMP_EN)
module nexys_starship_spawner
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int unsigned TICK_DIV      = 100000,
    parameter int unsigned MIN_GAP       = 250,
    parameter logic [10:0] BASE_THRESH   = 11'd8,
    parameter logic [10:0] MAX_THRESH    = 11'd256,
    parameter int unsigned RAMP_ATTEMPTS = 1000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        play_flag,
    input  logic [3:0]  occupied,
    input  logic [3:0]  spawn_ack,
    output logic [3:0]  spawn_req,
    output logic [7:0]  spawn_count,
    output logic [10:0] threshold,
    output logic        q_Idle,
    output logic        q_Run,
    output logic        q_Offer,
    output logic        q_Cool
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = (MIN_GAP > 0) ? GW'(MIN_GAP - 1) : '0;

    logic [15:0]   lfsr;
    logic [9:0]    draw_prob;
    logic [1:0]    draw_lane;
    logic [3:0]    lfsr_unused;

    logic [3:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    req_q, req_d;
    logic [7:0]    count_q, count_d;
    logic [10:0]   thresh_q, thresh_d;
    logic          attempt_tick;
    logic          lane_found;
    logic [1:0]    lane_sel;
    logic [1:0]    lane_cand;

    starship_lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (SEED),
        .q     (lfsr)
    );

    assign draw_prob    = lfsr[9:0];
    assign draw_lane    = lfsr[11:10];
    assign lfsr_unused  = lfsr[15:12];
    assign attempt_tick = (tick_q == TICK_LAST);

    // First free lane scanning s, s+1, s+2, s+3 (mod 4); lowest offset wins
    always_comb begin
        lane_found = 1'b0;
        lane_sel   = 2'd0;
        lane_cand  = 2'd0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            lane_cand = draw_lane + 2'(k);
            if (!occupied[lane_cand]) begin
                lane_found = 1'b1;
                lane_sel   = lane_cand;
            end
        end
    end

    // Game FSM: attempt scheduling, request handshake, cooldown, spawn counting
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        gap_d   = gap_q;
        req_d   = req_q;
        count_d = count_q;
        if (!play_flag) begin
            // Leaving play drops any pending request without counting it
            state_d = IDLE;
            req_d   = 4'b0000;
            tick_d  = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    count_d = 8'd0;
                    tick_d  = '0;
                end
                RUN: begin
                    tick_d = attempt_tick ? '0 : tick_q + TW'(1);
                    if (attempt_tick && ({1'b0, draw_prob} < thresh_q) && lane_found) begin
                        req_d   = lane_onehot(lane_sel);
                        state_d = OFFER;
                    end
                end
                OFFER: begin
                    if (|(spawn_ack & req_q)) begin
                        req_d   = 4'b0000;
                        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                        state_d = COOL;
                        tick_d  = '0;
                        gap_d   = '0;
                    end
                end
                COOL: begin
                    tick_d = attempt_tick ? '0 : tick_q + TW'(1);
                    if (MIN_GAP == 0) begin
                        state_d = RUN;
                        tick_d  = '0;
                    end else if (attempt_tick) begin
                        if (gap_q == GAP_LAST) begin
                            state_d = RUN;
                            gap_d   = '0;
                        end else begin
                            gap_d = gap_q + GW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 4'b0000;
                    tick_d  = '0;
                    gap_d   = '0;
                end
            endcase
        end
    end

`ifdef NEXYS_STARSHIP_SPAWN_RAMP_EN
    localparam int RW = (RAMP_ATTEMPTS > 1) ? $clog2(RAMP_ATTEMPTS) : 1;
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_ATTEMPTS - 1);

    logic [RW-1:0] ramp_q, ramp_d;

    // Every RAMP_ATTEMPTS attempt-ticks in RUN/COOL raise the threshold up to the ceiling
    always_comb begin
        ramp_d   = ramp_q;
        thresh_d = thresh_q;
        if (!play_flag || (state_q == IDLE)) begin
            ramp_d   = '0;
            thresh_d = BASE_THRESH;
        end else if (((state_q == RUN) || (state_q == COOL)) && attempt_tick) begin
            if (ramp_q == RAMP_LAST) begin
                ramp_d = '0;
                if (thresh_q < MAX_THRESH) begin
                    thresh_d = thresh_q + 11'd1;
                end
            end else begin
                ramp_d = ramp_q + RW'(1);
            end
        end
    end

    // Ramp progress register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    // Fixed spawn probability
    always_comb begin
        thresh_d = BASE_THRESH;
    end
`endif

    // State and counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            gap_q    <= '0;
            req_q    <= 4'b0000;
            count_q  <= 8'd0;
            thresh_q <= BASE_THRESH;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            gap_q    <= gap_d;
            req_q    <= req_d;
            count_q  <= count_d;
            thresh_q <= thresh_d;
        end
    end

    assign spawn_req   = req_q;
    assign spawn_count = count_q;
    assign threshold   = thresh_q;
    assign q_Idle      = state_q[0];
    assign q_Run       = state_q[1];
    assign q_Offer     = state_q[2];
    assign q_Cool      = state_q[3];

endmodule

// File: tb/tb_nexys_starship_spawner.sv
// tb/tb_nexys_starship_spawner.sv - self-checking bench for nexys_starship_spawner (ramp: NEXYS_STARSHIP_SPAWN_RAMP_EN)
module tb_nexys_starship_spawner;

    localparam int TD  = 4;
    localparam int GAP = 2;
    localparam int RA  = 3;
`ifdef NEXYS_STARSHIP_SPAWN_RAMP_EN
    localparam int RAMP_ON = 1;
`else
    localparam int RAMP_ON = 0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_OFFER = 2;
    localparam int M_COOL  = 3;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic play_flag = 1'b0;
    logic [1:0][3:0]  occ = '0;
    logic [1:0][3:0]  ack = '0;
    logic [1:0][3:0]  req;
    logic [1:0][7:0]  cnt;
    logic [1:0][10:0] thr;
    logic [1:0] qi, qr, qo, qc;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    nexys_starship_spawner #(
        .SEED(16'hACE1), .TICK_DIV(TD), .MIN_GAP(GAP),
        .BASE_THRESH(11'd1024), .MAX_THRESH(11'd1024), .RAMP_ATTEMPTS(RA)
    ) dut (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag),
        .occupied(occ[0]), .spawn_ack(ack[0]), .spawn_req(req[0]),
        .spawn_count(cnt[0]), .threshold(thr[0]),
        .q_Idle(qi[0]), .q_Run(qr[0]), .q_Offer(qo[0]), .q_Cool(qc[0])
    );

    nexys_starship_spawner #(
        .SEED(16'hACE1), .TICK_DIV(TD), .MIN_GAP(GAP),
        .BASE_THRESH(11'd8), .MAX_THRESH(11'd10), .RAMP_ATTEMPTS(RA)
    ) dut_r (
        .Clk(Clk), .Reset(Reset), .play_flag(play_flag),
        .occupied(occ[1]), .spawn_ack(ack[1]), .spawn_req(req[1]),
        .spawn_count(cnt[1]), .threshold(thr[1]),
        .q_Idle(qi[1]), .q_Run(qr[1]), .q_Offer(qo[1]), .q_Cool(qc[1])
    );

    // Reference model: game phase, cycles spent in the phase, attempt-ticks this game
    int          m_mode  [2];
    int          m_cyc   [2];
    int          m_ticks [2];
    int          m_cnt   [2];
    logic [3:0]  m_req   [2];
    logic [15:0] m_lfsr;

    function automatic int base_of(int i);
        return (i == 0) ? 1024 : 8;
    endfunction

    function automatic int max_of(int i);
        return (i == 0) ? 1024 : 10;
    endfunction

    function automatic int thr_of(int i);
        int t;
        t = base_of(i);
        if (RAMP_ON != 0) begin
            t = base_of(i) + m_ticks[i] / RA;
            if (t > max_of(i)) t = max_of(i);
        end
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_cyc[i] = 0; m_ticks[i] = 0; m_cnt[i] = 0; m_req[i] = 4'b0000;
        end
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_step(input int i);
        int r, s, t, lane;
        bit found;
        r = int'(m_lfsr[9:0]);
        s = int'(m_lfsr[11:10]);
        t = thr_of(i);
        if (!play_flag) begin
            m_mode[i] = M_IDLE; m_req[i] = 4'b0000; m_cyc[i] = 0; m_ticks[i] = 0;
        end else begin
            case (m_mode[i])
                M_IDLE: begin
                    m_mode[i] = M_RUN; m_cnt[i] = 0; m_cyc[i] = 0; m_ticks[i] = 0;
                end
                M_RUN: begin
                    if (m_cyc[i] % TD == TD - 1) begin
                        m_ticks[i]++;
                        found = 0; lane = 0;
                        for (int k = 0; k < 4; k++) begin
                            if (!found && !occ[i][(s + k) % 4]) begin
                                found = 1; lane = (s + k) % 4;
                            end
                        end
                        if (r < t && found) begin
                            m_req[i] = 4'(1 << lane); m_mode[i] = M_OFFER; m_cyc[i] = 0;
                        end else begin
                            m_cyc[i]++;
                        end
                    end else begin
                        m_cyc[i]++;
                    end
                end
                M_OFFER: begin
                    if ((ack[i] & m_req[i]) != 4'b0000) begin
                        m_req[i] = 4'b0000;
                        m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
                        m_mode[i] = M_COOL; m_cyc[i] = 0;
                    end
                end
                default: begin
                    if (m_cyc[i] % TD == TD - 1) m_ticks[i]++;
                    if (m_cyc[i] == GAP * TD - 1) begin
                        m_mode[i] = M_RUN; m_cyc[i] = 0;
                    end else begin
                        m_cyc[i]++;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("req%0d", i), 32'(req[i]), 32'(m_req[i]));
            check($sformatf("count%0d", i), 32'(cnt[i]), 32'(m_cnt[i]));
            check($sformatf("threshold%0d", i), 32'(thr[i]), 32'(thr_of(i)));
            check($sformatf("state%0d", i), 32'({qc[i], qo[i], qr[i], qi[i]}), 32'(1 << m_mode[i]));
        end
        check("lfsr", 32'(dut.u_lfsr.q), 32'(m_lfsr));
    endtask

    // One clock: model follows the edge with the inputs in force, outputs compared on the falling edge
    task automatic cycle();
        @(posedge Clk);
        if (Reset) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        @(negedge Clk);
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    typedef struct {
        logic       pf;
        logic [3:0] occ;
        int         ack_mode;   // 0 none, 1 ack the requested lane, 2 ack a wrong lane
        int         n;
        logic [3:0] st;
        logic [3:0] mask;       // allowed request bits; 0 means no request
        int         cnt;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [3:0] prev_req;
        tbl[0]  = '{1'b1, 4'h0, 0, 1,   4'b0010, 4'h0, 0};
        tbl[1]  = '{1'b1, 4'h0, 0, 3,   4'b0010, 4'h0, 0};
        tbl[2]  = '{1'b1, 4'h0, 0, 1,   4'b0100, 4'hF, 0};
        tbl[3]  = '{1'b1, 4'h0, 1, 1,   4'b1000, 4'h0, 1};
        tbl[4]  = '{1'b1, 4'h0, 0, 7,   4'b1000, 4'h0, 1};
        tbl[5]  = '{1'b1, 4'h0, 0, 1,   4'b0010, 4'h0, 1};
        tbl[6]  = '{1'b1, 4'h0, 0, 4,   4'b0100, 4'hF, 1};
        tbl[7]  = '{1'b1, 4'h0, 1, 1,   4'b1000, 4'h0, 2};
        tbl[8]  = '{1'b1, 4'hF, 0, 8,   4'b0010, 4'h0, 2};
        tbl[9]  = '{1'b1, 4'hF, 0, 100, 4'b0010, 4'h0, 2};
        tbl[10] = '{1'b1, 4'h5, 0, 4,   4'b0100, 4'hA, 2};
        tbl[11] = '{1'b1, 4'h5, 2, 3,   4'b0100, 4'hA, 2};
        tbl[12] = '{1'b0, 4'h5, 1, 1,   4'b0001, 4'h0, 2};
        tbl[13] = '{1'b0, 4'h0, 0, 5,   4'b0001, 4'h0, 2};
        tbl[14] = '{1'b1, 4'h0, 0, 1,   4'b0010, 4'h0, 0};

        model_reset();
        occ[1] = 4'hF;
        cycles(2);
        Reset = 1'b0;
        cycles(2);

        // Directed timeline on the always-spawn instance
        for (int v = 0; v < 15; v++) begin
            play_flag = tbl[v].pf;
            occ[0]    = tbl[v].occ;
            prev_req  = req[0];
            for (int c = 0; c < tbl[v].n; c++) begin
                case (tbl[v].ack_mode)
                    1:       ack[0] = req[0];
                    2:       ack[0] = {req[0][2:0], req[0][3]};
                    default: ack[0] = 4'b0000;
                endcase
                cycle();
            end
            ack[0] = 4'b0000;
            check($sformatf("row%0d_state", v), 32'({qc[0], qo[0], qr[0], qi[0]}), 32'(tbl[v].st));
            check($sformatf("row%0d_count", v), 32'(cnt[0]), 32'(tbl[v].cnt));
            if (tbl[v].mask == 4'h0)
                check($sformatf("row%0d_req", v), 32'(req[0]), 32'h0);
            else
                check($sformatf("row%0d_req_lane", v),
                      32'($onehot(req[0]) && ((req[0] & ~tbl[v].mask) == 4'h0)), 32'd1);
            if (tbl[v].ack_mode == 2)
                check($sformatf("row%0d_req_stable", v), 32'(req[0]), 32'(prev_req));
        end

        // Threshold ramp on the low-threshold instance with all lanes busy
        play_flag = 1'b0;
        cycles(2);
        play_flag = 1'b1;
        occ[0] = 4'hF;
        occ[1] = 4'hF;
        cycle();
        cycles(11);
        check("ramp_before_3", 32'(thr[1]), 32'd8);
        cycle();
        check("ramp_after_3", 32'(thr[1]), (RAMP_ON != 0) ? 32'd9 : 32'd8);
        cycles(12);
        check("ramp_after_6", 32'(thr[1]), (RAMP_ON != 0) ? 32'd10 : 32'd8);
        cycles(12);
        check("ramp_saturated", 32'(thr[1]), (RAMP_ON != 0) ? 32'd10 : 32'd8);
        check("ramp_state_run", 32'(qr[1]), 32'd1);

        // Asynchronous reset while a request is pending
        play_flag = 1'b0;
        cycle();
        play_flag = 1'b1;
        occ[0] = 4'h0;
        cycles(5);
        ack[0] = req[0];
        cycle();
        ack[0] = 4'b0000;
        check("pre_reset_count", 32'(cnt[0]), 32'd1);
        cycles(8);
        cycles(4);
        check("pre_reset_offer", 32'(qo[0]), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("reset_req", 32'(req[0]), 32'h0);
        check("reset_count", 32'(cnt[0]), 32'h0);
        check("reset_idle", 32'(qi[0]), 32'd1);
        check("reset_lfsr", 32'(dut.u_lfsr.q), 32'hACE1);
        check("reset_threshold", 32'(thr[1]), 32'd8);
        cycle();
        Reset = 1'b0;

        // Randomized play against the model
        for (int c = 0; c < 3000; c++) begin
            if (play_flag) begin
                if ($urandom_range(0, 299) == 0) play_flag = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                play_flag = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 5) == 0) occ[i] = 4'($urandom);
                case ($urandom_range(0, 5))
                    0, 1:    ack[i] = req[i];
                    2:       ack[i] = 4'($urandom);
                    default: ack[i] = 4'b0000;
                endcase
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
